// File: rtl/router_pkg.sv
// Shared router constants and port-direction indices.
// read_en bit positions follow the dir_e ordering.
package router_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int FIFO_DEPTH = 4;
  localparam int NUM_DIRS   = 5;

  typedef enum logic [2:0] {
    DIR_N = 3'd0,
    DIR_E = 3'd1,
    DIR_W = 3'd2,
    DIR_S = 3'd3,
    DIR_L = 3'd4
  } dir_e;

  function automatic logic any_req(
    input logic [NUM_DIRS-1:0] req
  );
    logic hit;
    hit = 1'b0;
    for (int d = int'(DIR_N); d <= int'(DIR_L); d++)
      hit = hit | req[d];
    return hit;
  endfunction

endpackage

// File: rtl/rx_fifo_if.sv
// Upstream handshake plus arbiter read side of the RX FIFO.
// master drives the FIFO, slave is the FIFO itself.
interface rx_fifo_if #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int DEPTH      = router_pkg::FIFO_DEPTH
);
  import router_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic                  DRTS;
  logic [DATA_WIDTH-1:0] RX;
  logic                  CTS;
  logic [NUM_DIRS-1:0]   read_en;
  logic [DATA_WIDTH-1:0] Data_out;
  logic                  empty;
  logic                  full;
  logic [CW-1:0]         count;

  modport master (
    output DRTS, RX, read_en,
    input  CTS, Data_out, empty, full, count
  );

  modport slave (
    input  DRTS, RX, read_en,
    output CTS, Data_out, empty, full, count
  );

endinterface

// File: rtl/rx_fifo_mem.sv
// Flit storage: one synchronous write port, one async read port.
// Contents are intentionally left unreset.
module rx_fifo_mem #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int DEPTH      = router_pkg::FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rx_fifo.sv
// Router input FIFO: DRTS/CTS pulse handshake, binary
// wrap-bit pointers, flags and occupancy count.
module rx_fifo #(
  parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
  parameter int DEPTH      = router_pkg::FIFO_DEPTH
) (
  input  logic      clk,
  input  logic      rst,
  rx_fifo_if.slave  bus
);
  import router_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic                  cts;
  logic                  cts_nxt;
  logic                  wr;
  logic                  pop;
  logic                  empty;
  logic                  full;
  logic [DATA_WIDTH-1:0] rdata;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0])
              && (wr_ptr[AW] != rd_ptr[AW]);

  // CTS is a one-cycle grant; the write lands on the edge after it.
  always_comb begin
    cts_nxt = 1'b0;
    wr      = 1'b0;
    pop     = 1'b0;
    if (bus.DRTS && !cts && !full)
      cts_nxt = 1'b1;
    if (bus.DRTS && cts)
      wr = 1'b1;
    if (any_req(bus.read_en) && !empty)
      pop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cts    <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      cts <= cts_nxt;
      if (wr)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
    end
  end

  rx_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (wr),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (bus.RX),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign bus.CTS      = cts;
  assign bus.empty    = empty;
  assign bus.full     = full;
  assign bus.count    = wr_ptr - rd_ptr;
  assign bus.Data_out = empty ? '0 : rdata;

endmodule

// File: tb/tb_rx_fifo.sv
// Directed test of rx_fifo handshake, flags, wrap and reset.
module tb_rx_fifo;

  localparam int DW = 32;
  localparam int DP = 4;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  rx_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DP)) bus ();

  rx_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic [31:0] d);
    bus.DRTS = 1'b1;
    bus.RX   = d;
    step();
    chk("xfer_cts", 32'(bus.CTS), 32'd1);
    step();
    bus.DRTS = 1'b0;
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b0;
    bus.DRTS    = 1'b0;
    bus.RX      = '0;
    bus.read_en = '0;
    step();
    step();
    chk("rst_cts",   32'(bus.CTS),   32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full",  32'(bus.full),  32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_data",  bus.Data_out,   32'd0);
    rst = 1'b1;
    step();
    step();
    chk("idle_cts", 32'(bus.CTS), 32'd0);

    // single transfer
    bus.DRTS = 1'b1;
    bus.RX   = 32'hA5A5_0001;
    step();
    chk("t1_cts1",  32'(bus.CTS),   32'd1);
    chk("t1_empty", 32'(bus.empty), 32'd1);
    step();
    bus.DRTS = 1'b0;
    chk("t1_cts2",  32'(bus.CTS),   32'd0);
    chk("t1_empty2", 32'(bus.empty), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd1);
    chk("t1_data",  bus.Data_out,   32'hA5A5_0001);

    // reset and fill
    rst = 1'b0;
    #1;
    chk("rst2_count", 32'(bus.count), 32'd0);
    rst = 1'b1;
    step();
    xfer(32'h10);
    xfer(32'h11);
    xfer(32'h12);
    xfer(32'h13);
    chk("fill_full",  32'(bus.full),  32'd1);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_head",  bus.Data_out,   32'h10);
    bus.DRTS = 1'b1;
    bus.RX   = 32'h14;
    step();
    chk("full_cts_a", 32'(bus.CTS), 32'd0);
    step();
    chk("full_cts_b", 32'(bus.CTS), 32'd0);

    // pop one from full, CTS pulses once
    bus.read_en = 5'b00100;
    step();
    bus.read_en = '0;
    chk("pop_count", 32'(bus.count), 32'd3);
    chk("pop_cts",   32'(bus.CTS),   32'd0);
    chk("pop_head",  bus.Data_out,   32'h11);
    step();
    chk("refill_cts", 32'(bus.CTS), 32'd1);
    step();
    chk("refill_cts0",  32'(bus.CTS),   32'd0);
    chk("refill_count", 32'(bus.count), 32'd4);
    chk("refill_full",  32'(bus.full),  32'd1);
    step();
    chk("refill_cts1", 32'(bus.CTS), 32'd0);
    bus.DRTS = 1'b0;

    // down to two, then write + pop on one edge
    bus.read_en = 5'b00001;
    step();
    chk("drain_head1", bus.Data_out, 32'h12);
    step();
    bus.read_en = '0;
    chk("two_count", 32'(bus.count), 32'd2);
    chk("two_head",  bus.Data_out,   32'h13);
    bus.DRTS = 1'b1;
    bus.RX   = 32'h15;
    step();
    chk("sim_cts", 32'(bus.CTS), 32'd1);
    bus.read_en = 5'b10001;
    step();
    bus.read_en = '0;
    bus.DRTS    = 1'b0;
    chk("sim_count", 32'(bus.count), 32'd2);
    chk("sim_head",  bus.Data_out,   32'h14);
    bus.read_en = 5'b01000;
    step();
    chk("sim_head2", bus.Data_out, 32'h15);
    step();
    bus.read_en = '0;
    chk("drain_empty", 32'(bus.empty), 32'd1);
    chk("drain_data",  bus.Data_out,   32'd0);

    // eight write/pop pairs across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      xfer(32'(i));
      chk("wrap_data",  bus.Data_out,   32'(i));
      chk("wrap_count", 32'(bus.count), 32'd1);
      bus.read_en = 5'b10000;
      step();
      bus.read_en = '0;
      chk("wrap_empty", 32'(bus.empty), 32'd1);
    end

    // protocol violation: DRTS drops while CTS high
    bus.DRTS = 1'b1;
    bus.RX   = 32'hDEAD;
    step();
    chk("viol_cts", 32'(bus.CTS), 32'd1);
    bus.DRTS = 1'b0;
    step();
    chk("viol_count", 32'(bus.count), 32'd0);
    chk("viol_empty", 32'(bus.empty), 32'd1);

    // pop request while empty
    bus.read_en = 5'b11111;
    step();
    step();
    bus.read_en = '0;
    chk("epop_count", 32'(bus.count), 32'd0);
    chk("epop_empty", 32'(bus.empty), 32'd1);
    chk("epop_full",  32'(bus.full),  32'd0);
    chk("epop_data",  bus.Data_out,   32'd0);

    // async reset mid-handshake
    bus.DRTS = 1'b1;
    bus.RX   = 32'hBEEF;
    step();
    chk("mid_cts", 32'(bus.CTS), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cts",   32'(bus.CTS),   32'd0);
    chk("arst_count", 32'(bus.count), 32'd0);
    step();
    chk("arst_empty", 32'(bus.empty), 32'd1);
    bus.DRTS = 1'b0;
    rst      = 1'b1;
    step();
    chk("post_cts",   32'(bus.CTS),   32'd0);
    chk("post_count", 32'(bus.count), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_fifo.md
RX_FIFO -- requirements
Module: rx_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 32, flit width in bits.
REQ-002 Parameter DEPTH, default 4, flit slots; SHALL be a power of two, at least 2.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 DRTS  input  1  upstream request-to-send; held high by upstream until a transfer completes.
REQ-006 RX  input  DATA_WIDTH  upstream flit; valid while DRTS high.
REQ-007 CTS  output  1  registered clear-to-send returned to upstream (its DCTS).
REQ-008 read_en  input  5  pop request from output arbiters, bit order N,E,W,S,L.
REQ-009 Data_out  output  DATA_WIDTH  head-of-queue flit.
REQ-010 empty  output  1  queue holds no flits.
REQ-011 full  output  1  queue holds DEPTH flits.
REQ-012 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-013 Handshake: CTS next value SHALL be 1 iff DRTS==1, CTS==0 and full==0; otherwise 0.
REQ-014 CTS SHALL never be high on two consecutive cycles; each CTS pulse is exactly one cycle.
REQ-015 Write: on a posedge where DRTS==1 and CTS==1, RX SHALL be stored at the write pointer, and the write pointer SHALL advance by one.
REQ-016 DRTS falling while CTS is high (upstream protocol violation) SHALL cause no write.
REQ-017 Pop: on a posedge where read_en!=0 and empty==0, the read pointer SHALL advance by one.
REQ-018 More than one read_en bit high SHALL still pop exactly one flit.
REQ-019 read_en!=0 while empty SHALL be ignored: no pointer change, no error state.
REQ-020 A simultaneous write and pop SHALL leave count unchanged and both pointers advanced.
REQ-021 Data_out SHALL be the combinational read of the slot at the read pointer when empty==0, and all-zero when empty==1.
REQ-022 Data_out SHALL reflect a written flit on the cycle after the write edge; there is no write-to-read bypass.
REQ-023 Pointers SHALL be binary with $clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
REQ-024 full SHALL be asserted when the pointer indices are equal and the wrap bits differ.
REQ-025 empty SHALL be asserted when the pointers are equal, wrap bit included.
REQ-026 count SHALL equal the write pointer minus the read pointer, modulo 2*DEPTH.
REQ-027 No overflow is possible: CTS is raised only when not full, and the cycle that raises it performs no write.

Reset
REQ-028 While rst==0: CTS=0, both pointers=0, empty=1, full=0, count=0, Data_out=0.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset asserted mid-handshake (CTS high) SHALL drop CTS immediately and discard the flit.
REQ-031 The first CTS after reset release SHALL occur no earlier than the first posedge with DRTS high.

Structure
REQ-032 Shared package router_pkg SHALL hold DATA_WIDTH, FIFO_DEPTH and a direction-index enum (DIR_N, DIR_E, DIR_W, DIR_S, DIR_L) used for the read_en bit order.
REQ-033 Storage SHALL be a sub-module rx_fifo_mem: a DEPTH x DATA_WIDTH register array with one write port and one asynchronous read port.
REQ-034 Handshake, pointers and flags SHALL reside in rx_fifo.

Verification
REQ-035 Reset, then DRTS=1 with RX=0xA5A5_0001 -> CTS high on the first edge only; flit written at the second edge; then empty=0, count=1, Data_out=0xA5A5_0001.
REQ-036 Four back-to-back transfers with no reads -> full=1, count=4; DRTS held high afterwards -> CTS stays 0.
REQ-037 From full, read_en=5'b00100 for one cycle -> count=3; with DRTS still high, CTS pulses once on the next edge.
REQ-038 count=2, write and read_en=5'b10001 on the same edge -> count stays 2; Data_out advances to the next flit.
REQ-039 Eight write/pop pairs (pointer wrap) with RX=0..7 -> Data_out sequence 0..7 in order, no loss or duplication.
REQ-040 read_en=5'b11111 while empty -> no state change; rst pulled low while CTS=1 -> CTS=0 and count=0 asynchronously.
